spi_flash_dma_wr: RTL and testbench
===================================

SPI_FLASH_DMA_WR -- requirements
Module: spi_flash_dma_wr

Interface
REQ-001 Parameter: ADDR_W, 32, AHB address width.
REQ-002 Parameter: DATA_W, 32, data word width; equals FIFO read-data width.
REQ-003 Parameter: CNT_W, 24, word-count width.
REQ-004 ahbclk  in  1  sole clock; all state rising-edge.
REQ-005 ahbrst  in  1  reset, asynchronous assert, active-high.
REQ-006 i_start  in  1  one-cycle pulse; begins a transfer.
REQ-007 i_base_addr  in  ADDR_W  first destination byte address; sampled on accepted i_start.
REQ-008 i_word_cnt  in  CNT_W  number of words to move; sampled on accepted i_start.
REQ-009 i_fifo_empty  in  1  async-FIFO read-side empty flag.
REQ-010 i_fifo_rdata  in  DATA_W  FIFO head word; valid whenever i_fifo_empty=0 (first-word-fall-through).
REQ-011 o_fifo_rinc  out  1  FIFO pop strobe; one cycle per word.
REQ-012 o_addr  out  ADDR_W  AHB master address.
REQ-013 o_wr_data  out  DATA_W  AHB master write data.
REQ-014 o_rd0_wr1  out  1  transfer direction; 1 = write.
REQ-015 o_valid  out  1  request valid.
REQ-016 i_ready  in  1  master accepts request when o_valid=1 and i_ready=1 in the same cycle.
REQ-017 o_busy  out  1  high from the cycle after an accepted i_start through DONE.
REQ-018 o_done  out  1  one-cycle completion pulse.

Function
REQ-019 FSM states: IDLE, FETCH, ISSUE, DONE; all outputs registered.
REQ-020 IDLE: i_start with i_word_cnt!=0 -> latch addr/count, go FETCH.
REQ-021 IDLE: i_start with i_word_cnt=0 -> no bus activity; o_done pulses next cycle; stay IDLE.
REQ-022 i_start outside IDLE is ignored; latched addr/count unchanged.
REQ-023 FETCH: if i_fifo_empty=0 -> capture i_fifo_rdata into o_wr_data, assert o_fifo_rinc for exactly that cycle, go ISSUE; else wait, no pop.
REQ-024 ISSUE: o_valid=1, o_rd0_wr1=1; o_addr, o_wr_data stable until accepted.
REQ-025 ISSUE accept (i_ready=1): remaining-=1, o_addr+=4 next cycle; remaining reaches 0 -> DONE, else FETCH.
REQ-026 o_valid drops the cycle after acceptance; o_rd0_wr1 mirrors o_valid.
REQ-027 DONE: o_done=1 one cycle, o_busy=1; go IDLE.
REQ-028 Throughput: best case one word per 2 cycles (FETCH+ISSUE with i_ready=1).
REQ-029 Address arithmetic modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0x00000000, no error.
REQ-030 FIFO never popped when i_fifo_empty=1; at most i_word_cnt pops per transfer.
REQ-031 i_ready while o_valid=0 is ignored.

Reset
REQ-032 ahbrst=1 forces asynchronously: state IDLE, o_valid=0, o_rd0_wr1=0, o_fifo_rinc=0, o_busy=0, o_done=0, o_addr=0, o_wr_data=0, counters 0.
REQ-033 Reset mid-transfer aborts immediately; no o_done; pending words stay in FIFO; i_start accepted first clock edge after release.

Verification
REQ-034 i_start, base=0x2000_0000, cnt=3, FIFO holds A,B,C, i_ready=1 -> writes (0x2000_0000,A),(0x2000_0004,B),(0x2000_0008,C); 3 pops; o_done pulse once; 6 cycles from FETCH entry to DONE.
REQ-035 cnt=2, i_ready low 5 cycles during first ISSUE -> o_addr/o_wr_data/o_valid held constant all 5 cycles; single pop per word.
REQ-036 cnt=2, FIFO empty for 10 cycles then words arrive -> FSM waits in FETCH, o_fifo_rinc=0 while empty, completes normally.
REQ-037 cnt=0 -> o_valid never asserted, zero pops, o_done pulses next cycle.
REQ-038 base=0xFFFF_FFFC, cnt=2 -> second write address 0x0000_0000.
REQ-039 ahbrst asserted during ISSUE of word 2 of 4 -> all outputs 0 same cycle; no o_done; new i_start after release runs cleanly.

Source files
------------

// File: rtl/spi_flash_dma_wr.sv
// Drains words from a first-word-fall-through FIFO and writes them to consecutive
// AHB word addresses; one FETCH/ISSUE pair per word, all outputs registered.
module spi_flash_dma_wr #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 24
) (
  input  logic              ahbclk,
  input  logic              ahbrst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [CNT_W-1:0]  i_word_cnt,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_rdata,
  output logic              o_fifo_rinc,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_rd0_wr1,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, DONE} state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  remaining, remaining_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wr_data_nx;
  logic              valid_nx, rinc_nx, busy_nx, done_nx;

  always_ff @(posedge ahbclk or posedge ahbrst) begin
    if (ahbrst) begin
      state       <= IDLE;
      remaining   <= '0;
      o_addr      <= '0;
      o_wr_data   <= '0;
      o_valid     <= 1'b0;
      o_rd0_wr1   <= 1'b0;
      o_fifo_rinc <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_nx;
      remaining   <= remaining_nx;
      o_addr      <= addr_nx;
      o_wr_data   <= wr_data_nx;
      o_valid     <= valid_nx;
      o_rd0_wr1   <= valid_nx;
      o_fifo_rinc <= rinc_nx;
      o_busy      <= busy_nx;
      o_done      <= done_nx;
    end
  end

  // The pop strobe lands in the first ISSUE cycle; the FWFT head is untouched
  // until then, so the word captured in FETCH is the one being popped.
  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    addr_nx      = o_addr;
    wr_data_nx   = o_wr_data;
    valid_nx     = o_valid;
    rinc_nx      = 1'b0;
    busy_nx      = o_busy;
    done_nx      = 1'b0;
    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
        if (i_start) begin
          if (i_word_cnt != '0) begin
            remaining_nx = i_word_cnt;
            addr_nx      = i_base_addr;
            busy_nx      = 1'b1;
            state_nx     = FETCH;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      FETCH: begin
        if (!i_fifo_empty) begin
          wr_data_nx = i_fifo_rdata;
          rinc_nx    = 1'b1;
          valid_nx   = 1'b1;
          state_nx   = ISSUE;
        end
      end
      ISSUE: begin
        if (i_ready) begin
          valid_nx     = 1'b0;
          addr_nx      = o_addr + ADDR_W'(4);
          remaining_nx = remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = FETCH;
          end
        end
      end
      DONE: begin
        busy_nx  = 1'b0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_dma_wr.sv
// Directed bench for spi_flash_dma_wr: FWFT FIFO model, bus write logger,
// hand-computed expected addresses/data for each scenario.
module tb_spi_flash_dma_wr;

  logic        ahbclk;
  logic        ahbrst;
  logic        i_start;
  logic [31:0] i_base_addr;
  logic [23:0] i_word_cnt;
  logic        i_fifo_empty;
  logic [31:0] i_fifo_rdata;
  logic        o_fifo_rinc;
  logic [31:0] o_addr;
  logic [31:0] o_wr_data;
  logic        o_rd0_wr1;
  logic        o_valid;
  logic        i_ready;
  logic        o_busy;
  logic        o_done;

  spi_flash_dma_wr #(.ADDR_W(32), .DATA_W(32), .CNT_W(24)) dut (
    .ahbclk      (ahbclk),
    .ahbrst      (ahbrst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_word_cnt  (i_word_cnt),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_rdata(i_fifo_rdata),
    .o_fifo_rinc (o_fifo_rinc),
    .o_addr      (o_addr),
    .o_wr_data   (o_wr_data),
    .o_rd0_wr1   (o_rd0_wr1),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_done      (o_done)
  );

  initial begin
    ahbclk = 1'b0;
    forever #5 ahbclk = ~ahbclk;
  end

  // FWFT FIFO model: pushed by the stimulus, popped on o_fifo_rinc
  logic [31:0] fifo_mem [16];
  logic [7:0]  wr_ptr, rd_ptr;
  assign i_fifo_empty = (wr_ptr == rd_ptr);
  assign i_fifo_rdata = fifo_mem[rd_ptr[3:0]];

  int          pop_cnt, pop_empty_cnt, done_cnt, valid_cnt, wr_n;
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];

  initial begin
    rd_ptr = '0; pop_cnt = 0; pop_empty_cnt = 0;
    done_cnt = 0; valid_cnt = 0; wr_n = 0;
  end

  always @(posedge ahbclk) begin
    if (o_fifo_rinc) begin
      if (i_fifo_empty) pop_empty_cnt <= pop_empty_cnt + 1;
      else begin
        rd_ptr  <= rd_ptr + 8'd1;
        pop_cnt <= pop_cnt + 1;
      end
    end
    if (o_done) done_cnt <= done_cnt + 1;
    if (o_valid) valid_cnt <= valid_cnt + 1;
    if (o_valid && i_ready && o_rd0_wr1) begin
      log_addr[wr_n] <= o_addr;
      log_data[wr_n] <= o_wr_data;
      wr_n           <= wr_n + 1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic start(input logic [31:0] base, input logic [23:0] cnt);
    @(negedge ahbclk);
    i_start = 1'b1; i_base_addr = base; i_word_cnt = cnt;
    @(negedge ahbclk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!o_done && cyc < 200) begin
      @(negedge ahbclk);
      cyc++;
    end
    chk(tag, {95'd0, o_done}, 96'd1);
  endtask

  int cyc, w0, p0, d0, v0;

  initial begin
    ahbrst = 1'b0; i_start = 1'b0; i_base_addr = '0; i_word_cnt = '0;
    i_ready = 1'b0; wr_ptr = '0;
    #2 ahbrst = 1'b1;
    @(negedge ahbclk);
    chk("reset_outputs", {o_valid, o_rd0_wr1, o_fifo_rinc, o_busy, o_done, o_addr, o_wr_data}, 96'd0);
    @(negedge ahbclk);
    ahbrst = 1'b0;

    // three words, ready always high
    push(32'hAAAA_0001); push(32'hBBBB_0002); push(32'hCCCC_0003);
    i_ready = 1'b1;
    w0 = wr_n; p0 = pop_cnt; d0 = done_cnt;
    start(32'h2000_0000, 24'd3);
    chk("busy_after_start", {95'd0, o_busy}, 96'd1);
    wait_done("basic_done_seen", cyc);
    chk("basic_latency", 96'(cyc), 96'd6);
    chk("busy_in_done", {95'd0, o_busy}, 96'd1);
    @(negedge ahbclk);
    @(negedge ahbclk);
    chk("busy_cleared", {95'd0, o_busy}, 96'd0);
    chk("basic_writes", 96'(wr_n - w0), 96'd3);
    chk("basic_w0", {log_addr[w0], log_data[w0]}, {32'd0, 32'h2000_0000, 32'hAAAA_0001});
    chk("basic_w1", {log_addr[w0+1], log_data[w0+1]}, {32'd0, 32'h2000_0004, 32'hBBBB_0002});
    chk("basic_w2", {log_addr[w0+2], log_data[w0+2]}, {32'd0, 32'h2000_0008, 32'hCCCC_0003});
    chk("basic_pops", 96'(pop_cnt - p0), 96'd3);
    chk("basic_done_once", 96'(done_cnt - d0), 96'd1);

    // back-pressure on the first ISSUE
    push(32'hDDDD_0004); push(32'hEEEE_0005);
    i_ready = 1'b0;
    w0 = wr_n; p0 = pop_cnt;
    start(32'h1000_0100, 24'd2);
    cyc = 0;
    while (!o_valid && cyc < 50) begin @(negedge ahbclk); cyc++; end
    for (int i = 0; i < 5; i++) begin
      chk("hold_req", {o_valid, o_rd0_wr1, o_addr, o_wr_data}, {62'd0, 1'b1, 1'b1, 32'h1000_0100, 32'hDDDD_0004});
      @(negedge ahbclk);
    end
    chk("hold_single_pop", 96'(pop_cnt - p0), 96'd1);
    i_ready = 1'b1;
    wait_done("stall_done_seen", cyc);
    @(negedge ahbclk);
    chk("stall_pops", 96'(pop_cnt - p0), 96'd2);
    chk("stall_w0", {log_addr[w0], log_data[w0]}, {32'd0, 32'h1000_0100, 32'hDDDD_0004});
    chk("stall_w1", {log_addr[w0+1], log_data[w0+1]}, {32'd0, 32'h1000_0104, 32'hEEEE_0005});

    // FIFO empty for 10 cycles
    w0 = wr_n; p0 = pop_cnt;
    start(32'h4000_0000, 24'd2);
    for (int i = 0; i < 10; i++) begin
      chk("empty_wait", {o_fifo_rinc, o_valid, o_busy}, {93'd0, 3'b001});
      @(negedge ahbclk);
    end
    push(32'h1111_0006); push(32'h2222_0007);
    wait_done("empty_done_seen", cyc);
    @(negedge ahbclk);
    chk("empty_pops", 96'(pop_cnt - p0), 96'd2);
    chk("empty_w0", {log_addr[w0], log_data[w0]}, {32'd0, 32'h4000_0000, 32'h1111_0006});
    chk("empty_w1", {log_addr[w0+1], log_data[w0+1]}, {32'd0, 32'h4000_0004, 32'h2222_0007});

    // zero word count
    p0 = pop_cnt; v0 = valid_cnt; d0 = done_cnt;
    start(32'h5000_0000, 24'd0);
    chk("zero_done_pulse", {o_done, o_busy}, {94'd0, 2'b10});
    @(negedge ahbclk);
    chk("zero_done_low", {95'd0, o_done}, 96'd0);
    @(negedge ahbclk);
    chk("zero_no_valid", 96'(valid_cnt - v0), 96'd0);
    chk("zero_no_pop", 96'(pop_cnt - p0), 96'd0);
    chk("zero_done_once", 96'(done_cnt - d0), 96'd1);

    // address wrap
    push(32'h3333_0008); push(32'h4444_0009);
    w0 = wr_n;
    start(32'hFFFF_FFFC, 24'd2);
    wait_done("wrap_done_seen", cyc);
    @(negedge ahbclk);
    chk("wrap_w0", {log_addr[w0], log_data[w0]}, {32'd0, 32'hFFFF_FFFC, 32'h3333_0008});
    chk("wrap_w1", {log_addr[w0+1], log_data[w0+1]}, {32'd0, 32'h0000_0000, 32'h4444_0009});

    // reset during ISSUE of word 2 of 4
    push(32'h5555_000A); push(32'h6666_000B); push(32'h7777_000C); push(32'h8888_000D);
    w0 = wr_n; p0 = pop_cnt; d0 = done_cnt;
    start(32'h6000_0000, 24'd4);
    cyc = 0;
    while (!(o_valid && (wr_n - w0) == 1) && cyc < 50) begin @(negedge ahbclk); cyc++; end
    chk("abort_at_word2", {o_valid, o_wr_data}, {63'd0, 1'b1, 32'h6666_000B});
    ahbrst = 1'b1;
    #1;
    chk("abort_outputs_zero", {o_valid, o_rd0_wr1, o_fifo_rinc, o_busy, o_done, o_addr, o_wr_data}, 96'd0);
    @(negedge ahbclk);
    @(negedge ahbclk);
    chk("abort_no_done", 96'(done_cnt - d0), 96'd0);
    chk("abort_pops", 96'(pop_cnt - p0), 96'd1);
    ahbrst = 1'b0;
    i_start = 1'b1; i_base_addr = 32'h3000_0000; i_word_cnt = 24'd3;
    w0 = wr_n;
    @(negedge ahbclk);
    i_start = 1'b0;
    chk("restart_busy", {95'd0, o_busy}, 96'd1);
    wait_done("restart_done_seen", cyc);
    @(negedge ahbclk);
    chk("restart_w0", {log_addr[w0], log_data[w0]}, {32'd0, 32'h3000_0000, 32'h6666_000B});
    chk("restart_w1", {log_addr[w0+1], log_data[w0+1]}, {32'd0, 32'h3000_0004, 32'h7777_000C});
    chk("restart_w2", {log_addr[w0+2], log_data[w0+2]}, {32'd0, 32'h3000_0008, 32'h8888_000D});
    chk("never_pop_empty", 96'(pop_empty_cnt), 96'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
